// File: rtl/afifo_rmon_capture.sv
// Read-side transaction capture unit for the async FIFO bench.
// Every accepted read (rinc && !rempty && mon_en) is counted, and the read
// data is optionally filtered by change-only mode. It is then stamped with a
// free-running timestamp and queued in a DEPTH-entry capture buffer. A
// consumer drains that buffer through a valid/ready port. Underflow attempts,
// overflow drops and accepted reads are tracked in saturating counters, with
// sticky flags alongside.
module afifo_rmon_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       mon_en,
  input  logic                       chg_only,
  input  logic                       clr,
  input  logic                       rinc,
  input  logic                       rempty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       cap_valid,
  input  logic                       cap_ready,
  output logic [DATA_WIDTH-1:0]      cap_data,
  output logic [TS_WIDTH-1:0]        cap_ts,
  output logic [CNT_WIDTH-1:0]       txn_cnt,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic [CNT_WIDTH-1:0]       unf_cnt,
  output logic                       ovf,
  output logic                       unf,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

  // Pointers carry one extra wrap bit, so full and empty are distinguishable.
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts   [DEPTH];

  logic [TS_WIDTH-1:0]   ts;
  logic [DATA_WIDTH-1:0] last;
  logic                  last_valid;

  logic acc, want, full, push, pop, drop, unf_evt;

  // Saturating increment shared by the three event counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == FULL_LEVEL);
  assign cap_valid = (level != '0);
  // The head is read straight out of registered storage. It is masked while
  // the buffer is empty, so the outputs read 0 out of reset.
  assign cap_data  = cap_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
  assign cap_ts    = cap_valid ? mem_ts[rd_ptr[AW-1:0]]   : '0;

  // Decode this cycle's acceptance, capture, push/pop and error events.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    acc     = 1'b0;
    want    = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    unf_evt = 1'b0;
    pop     = cap_valid && cap_ready;
    if (mon_en) begin
      acc     = rinc && !rempty;
      unf_evt = rinc && rempty;
    end
    want = acc && (!chg_only || !last_valid || (rdata != last));
    push = want && (!full || pop);
    drop = want && full && !pop;
  end

  // Free-running timestamp; only reset restarts it, clr leaves it alone.
  always_ff @(posedge rclk) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
    if (rrst) ts <= '0;
    else      ts <= ts + TS_WIDTH'(1);
  end

  // Buffer pointers; reset empties the buffer without counting drops.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Capture storage: write {timestamp, data} at the tail on push.
  always_ff @(posedge rclk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= rdata;
      mem_ts[wr_ptr[AW-1:0]]   <= ts;
    end
  end

  // Last-captured word for change-only filtering; updated even when the push drops.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      last       <= '0;
      last_valid <= 1'b0;
    end else if (want) begin
      last       <= rdata;
      last_valid <= 1'b1;
    end
  end

  // Saturating counters and sticky flags; clr takes priority over any increment.
  always_ff @(posedge rclk) begin
    if (rrst || clr) begin
      txn_cnt  <= '0;
      drop_cnt <= '0;
      unf_cnt  <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      if (acc)     txn_cnt  <= sat_inc(txn_cnt);
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        ovf      <= 1'b1;
      end
      if (unf_evt) begin
        unf_cnt  <= sat_inc(unf_cnt);
        unf      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_afifo_rmon_capture.sv
// Directed bench for afifo_rmon_capture. A vector table covers filtering,
// enable gating, underflow and clr. Hand-written sequences cover first-capture
// latency, overflow, push/pop at full, ordered drain and mid-run reset.
module tb_afifo_rmon_capture;

  localparam int DW = 32;
  localparam int TW = 16;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rrst, mon_en, chg_only, clr, rinc, rempty, cap_ready;
  logic [DW-1:0] rdata;
  logic          cap_valid, ovf, unf;
  logic [DW-1:0] cap_data;
  logic [TW-1:0] cap_ts;
  logic [CW-1:0] txn_cnt, drop_cnt, unf_cnt;
  logic [4:0]    level;

  int total = 0;
  int bad   = 0;

  // Timestamp model: counts clock edges since the last reset edge.
  logic [TW-1:0] ts_model = '0;
  logic [TW-1:0] cur_ts   = '0;

  afifo_rmon_capture #(.DATA_WIDTH(DW), .DEPTH(16), .TS_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .rclk(rclk), .rrst(rrst), .mon_en(mon_en), .chg_only(chg_only), .clr(clr),
    .rinc(rinc), .rempty(rempty), .rdata(rdata), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_data(cap_data), .cap_ts(cap_ts),
    .txn_cnt(txn_cnt), .drop_cnt(drop_cnt), .unf_cnt(unf_cnt),
    .ovf(ovf), .unf(unf), .level(level)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic          en, chg, cl, inc, emp, rdy;
    logic [DW-1:0] data;
    logic          e_valid;
    logic [4:0]    e_level;
    logic [DW-1:0] e_head;
    logic [CW-1:0] e_txn, e_unf, e_drop;
    logic          e_ovf, e_unf_f;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic en, logic chg, logic cl, logic inc, logic emp, logic rdy,
                              logic [DW-1:0] data, logic e_valid, logic [4:0] e_level,
                              logic [DW-1:0] e_head, logic [CW-1:0] e_txn,
                              logic [CW-1:0] e_unf, logic [CW-1:0] e_drop,
                              logic e_ovf, logic e_unf_f);
    vec_t v;
    v.en = en; v.chg = chg; v.cl = cl; v.inc = inc; v.emp = emp; v.rdy = rdy;
    v.data = data; v.e_valid = e_valid; v.e_level = e_level; v.e_head = e_head;
    v.e_txn = e_txn; v.e_unf = e_unf; v.e_drop = e_drop;
    v.e_ovf = e_ovf; v.e_unf_f = e_unf_f;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs are already applied; outputs are sampled 1ns after the edge.
  task automatic step();
    cur_ts = ts_model;
    @(posedge rclk);
    ts_model = rrst ? '0 : ts_model + TW'(1);
    #1;
  endtask

  task automatic drive(input logic en, input logic chg, input logic cl, input logic inc,
                       input logic emp, input logic rdy, input logic [DW-1:0] data);
    mon_en = en; chg_only = chg; clr = cl; rinc = inc; rempty = emp;
    cap_ready = rdy; rdata = data;
  endtask

  task automatic check_counts(input string tag, input logic [CW-1:0] t, input logic [CW-1:0] u,
                              input logic [CW-1:0] d, input logic o, input logic f);
    check({tag, ".txn"},  64'(txn_cnt),  64'(t));
    check({tag, ".unf"},  64'(unf_cnt),  64'(u));
    check({tag, ".drop"}, 64'(drop_cnt), 64'(d));
    check({tag, ".ovf"},  64'(ovf),      64'(o));
    check({tag, ".unff"}, 64'(unf),      64'(f));
  endtask

  logic [DW-1:0] exp_d [$];
  logic [TW-1:0] exp_t [$];

  initial begin
    // Watchdog: the flow is step-bounded, but never let the run hang.
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(); step();
    check("rst.valid", 64'(cap_valid), 64'd0);
    check("rst.level", 64'(level), 64'd0);
    check("rst.data",  64'(cap_data), 64'd0);
    check("rst.ts",    64'(cap_ts), 64'd0);
    check_counts("rst", 0, 0, 0, 1'b0, 1'b0);
    rrst = 1'b0;

    // First capture at timestamp 5: five idle edges, then one accepted read.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("first.valid", 64'(cap_valid), 64'd1);
    check("first.data",  64'(cap_data), 64'hA5A5_0001);
    check("first.ts",    64'(cap_ts), 64'd5);
    check("first.txn",   64'(txn_cnt), 64'd1);
    check("first.level", 64'(level), 64'd1);
    // Head stays stable while not accepted.
    step();
    check("hold.data", 64'(cap_data), 64'hA5A5_0001);
    check("hold.ts",   64'(cap_ts), 64'd5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    step();
    check("pop1.level", 64'(level), 64'd0);
    check("pop1.txn",   64'(txn_cnt), 64'd0);

    // No rinc: toggling data must not capture.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i % 2 == 0) ? 32'hFFFF_0000 : 32'h0000_FFFF);
      step();
    end
    check("norinc.level", 64'(level), 64'd0);
    check("norinc.txn",   64'(txn_cnt), 64'd0);

    //             en   chg  clr  inc  emp  rdy  data          vld lvl head txn unf drop ovf unf
    vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h1111_1111,1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h2222_2222,1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h3333_3333,1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[5]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd7,        1'b1,5'd1,32'd7,16'd1,16'd0,16'd0,1'b0,1'b0);
    vecs[6]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd7,        1'b1,5'd1,32'd7,16'd2,16'd0,16'd0,1'b0,1'b0);
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd7,        1'b1,5'd1,32'd7,16'd3,16'd0,16'd0,1'b0,1'b0);
    vecs[8]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd9,        1'b1,5'd2,32'd7,16'd4,16'd0,16'd0,1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd9,        1'b1,5'd2,32'd7,16'd5,16'd0,16'd0,1'b0,1'b0);
    vecs[10] = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd7,        1'b1,5'd3,32'd7,16'd6,16'd0,16'd0,1'b0,1'b0);
    vecs[11] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        1'b1,5'd2,32'd9,16'd6,16'd0,16'd0,1'b0,1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        1'b1,5'd1,32'd7,16'd6,16'd0,16'd0,1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,5'd0,32'd0,16'd6,16'd0,16'd0,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'd0,16'd6,16'd1,16'd0,1'b0,1'b1);
    vecs[15] = mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'd0,16'd6,16'd2,16'd0,1'b0,1'b1);
    vecs[16] = mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'd0,16'd6,16'd3,16'd0,1'b0,1'b1);
    vecs[17] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[18] = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'd7,        1'b0,5'd0,32'd0,16'd1,16'd0,16'd0,1'b0,1'b0);
    vecs[19] = mk(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'd8,        1'b1,5'd1,32'd8,16'd0,16'd0,16'd0,1'b0,1'b0);
    vecs[20] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,5'd0,32'd0,16'd0,16'd0,16'd0,1'b0,1'b0);

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].en, vecs[i].chg, vecs[i].cl, vecs[i].inc, vecs[i].emp, vecs[i].rdy, vecs[i].data);
      step();
      check({tag, ".valid"}, 64'(cap_valid), 64'(vecs[i].e_valid));
      check({tag, ".level"}, 64'(level), 64'(vecs[i].e_level));
      if (vecs[i].e_valid) check({tag, ".head"}, 64'(cap_data), 64'(vecs[i].e_head));
      check_counts(tag, vecs[i].e_txn, vecs[i].e_unf, vecs[i].e_drop, vecs[i].e_ovf, vecs[i].e_unf_f);
    end

    // Overflow: 18 accepted reads into a 16-entry buffer with no consumer.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
      step();
      if (i < 16) begin
        exp_d.push_back(32'h1000 + 32'(i));
        exp_t.push_back(cur_ts);
      end
    end
    check("ovf.level", 64'(level), 64'd16);
    check_counts("ovf", 16'd18, 16'd0, 16'd2, 1'b1, 1'b0);

    // Push and pop together while full: no drop, tail gets the new word.
    check("pp.head", 64'(cap_data), 64'(exp_d[0]));
    check("pp.ts",   64'(cap_ts), 64'(exp_t[0]));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000);
    step();
    void'(exp_d.pop_front());
    void'(exp_t.pop_front());
    exp_d.push_back(32'h2000);
    exp_t.push_back(cur_ts);
    check("pp.level", 64'(level), 64'd16);
    check("pp.drop",  64'(drop_cnt), 64'd2);
    check("pp.txn",   64'(txn_cnt), 64'd19);

    // Drain in order with exact timestamps.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d.valid", k), 64'(cap_valid), 64'd1);
      check($sformatf("drain%0d.data", k), 64'(cap_data), 64'(exp_d[k]));
      check($sformatf("drain%0d.ts", k),   64'(cap_ts), 64'(exp_t[k]));
      step();
    end
    check("drain.level", 64'(level), 64'd0);
    check("drain.valid", 64'(cap_valid), 64'd0);

    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_counts("clr2", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);

    // Reset mid-operation discards buffered entries and clears last_valid.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55);
    step();
    rdata = 32'h56;
    step();
    check("mid.level", 64'(level), 64'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    check("midrst.valid", 64'(cap_valid), 64'd0);
    check("midrst.level", 64'(level), 64'd0);
    check_counts("midrst", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("postrst.level", 64'(level), 64'd1);
    check("postrst.data",  64'(cap_data), 64'd0);
    check("postrst.ts",    64'(cap_ts), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
